// File: rtl/soi_trace_pkg.sv
// Shared types for the signal-of-interest trace monitor: event codes, FSM states
// and the non-timestamp part of a trace entry.
package soi_trace_pkg;

    typedef enum logic [1:0] {
        EV_NONE   = 2'b00,
        EV_CHANGE = 2'b01,
        EV_FAULT  = 2'b10,
        EV_ARM    = 2'b11
    } ev_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

    // Trace entry is {ts, ev_tag_t}; ts width is set per instance, so it stays outside the struct.
    typedef struct packed {
        ev_code_t   code;
        logic [2:0] soi;
    } ev_tag_t;

    localparam int WARMUP_CYCLES = 2;

    // {o3,o2,o1}: o3 must always be the complement of o2.
    function automatic logic invariant_broken(input logic [2:0] soi);
        return soi[2] == soi[1];
    endfunction

endpackage

// File: rtl/soi_trace_fifo.sv
// Synchronous trace FIFO with first-word-fall-through output; when empty the
// output holds the last entry popped.
module soi_trace_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);
    assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/soi_trace_monitor.sv
// Watches {o3,o2,o1}, checks o3 == ~o2 and logs timestamped ARM/CHANGE/FAULT
// entries into a trace FIFO drained over valid/ready.
//
//  state   | meaning
//  IDLE    | ts held at 0, nothing logged, waiting for arm
//  WARMUP  | two cycles letting soi_prev settle, ts counting, no checks
//  MONITOR | ts counting, CHANGE/FAULT entries logged
//  FROZEN  | fault seen with stop-on-fault: ts halted, FIFO still drains
module soi_trace_monitor
    import soi_trace_pkg::*;
#(
    parameter int TS_W          = 16,
    parameter int DEPTH         = 8,
    parameter bit STOP_ON_FAULT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_arm,
    input  logic            i_clear,
    input  logic [2:0]      i_soi,
    output logic            o_ev_valid,
    input  logic            i_ev_ready,
    output logic [TS_W+4:0] o_ev_data,
    output logic            o_fault,
    output logic [7:0]      o_ovf_cnt,
    output logic [1:0]      o_state
);
    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_soi_q;
    logic [2:0]      r_soi_prev;
    logic [TS_W-1:0] r_ts;
    logic [1:0]      r_warm_cnt;
    logic            r_fault;
    logic [7:0]      r_ovf_cnt;
    logic            w_push;
    logic            w_set_fault;
    ev_tag_t         w_tag;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_fault = 1'b0;
        w_tag.code  = EV_NONE;
        w_tag.soi   = r_soi_q;
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        w_state_nxt = ST_WARMUP;
                        w_push      = 1'b1;
                        w_tag.code  = EV_ARM;
                    end
                end
                ST_WARMUP: begin
                    if (r_warm_cnt == 2'(WARMUP_CYCLES - 1))
                        w_state_nxt = ST_MONITOR;
                end
                ST_MONITOR: begin
                    // A fault that is also a change is logged once, as FAULT.
                    if (invariant_broken(r_soi_q)) begin
                        w_push      = 1'b1;
                        w_set_fault = 1'b1;
                        w_tag.code  = EV_FAULT;
                        if (STOP_ON_FAULT)
                            w_state_nxt = ST_FROZEN;
                    end else if (r_soi_q != r_soi_prev) begin
                        w_push     = 1'b1;
                        w_tag.code = EV_CHANGE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_drop = w_push & w_full & ~i_ev_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_soi_q    <= '0;
            r_soi_prev <= '0;
            r_ts       <= '0;
            r_warm_cnt <= '0;
            r_fault    <= 1'b0;
            r_ovf_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_soi_q <= i_soi;
            if (r_state == ST_WARMUP)
                r_warm_cnt <= r_warm_cnt + 2'd1;
            else
                r_warm_cnt <= '0;
            if (i_clear) begin
                r_ts      <= '0;
                r_fault   <= 1'b0;
                r_ovf_cnt <= '0;
            end else begin
                if (r_state == ST_WARMUP || r_state == ST_MONITOR) begin
                    r_ts       <= r_ts + TS_W'(1);
                    r_soi_prev <= r_soi_q;
                end
                if (w_set_fault)
                    r_fault <= 1'b1;
                if (w_drop && r_ovf_cnt != 8'hFF)
                    r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    soi_trace_fifo #(
        .WIDTH (TS_W + 5),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_flush (i_clear),
        .i_push  (w_push),
        .i_data  ({r_ts, w_tag}),
        .i_pop   (i_ev_ready),
        .o_data  (o_ev_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_ev_valid = ~w_empty;
    assign o_fault    = r_fault;
    assign o_ovf_cnt  = r_ovf_cnt;
    assign o_state    = r_state;

endmodule
